// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//
// Front-end timing stage for the Tetris core. Turns the three raw active-low
// push-buttons into clean single-cycle move requests and generates the
// periodic gravity tick. A fixed-priority arbiter (left > right > rot > grav)
// guarantees the four request outputs are one-hot-or-zero in every cycle, so
// no request is lost to the game FSM's priority chain.
//
// Optional feature: define AUTOREPEAT_EN to make left/right auto-repeat while
// held (first repeat DAS_DELAY cycles after the press event, then one every
// DAS_RATE cycles). Without the macro each press yields exactly one event.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable cycles to accept a button change
//   GRAV_PERIOD      gravity tick period in cycles
//   DAS_DELAY        hold time before first auto-repeat (AUTOREPEAT_EN only)
//   DAS_RATE         cycles between later auto-repeats (AUTOREPEAT_EN only)
//
// Ports:
//   CLOCK_50      in   system clock
//   resetn        in   synchronous active-low reset
//   key_left_n    in   raw left button, asynchronous, low = pressed
//   key_right_n   in   raw right button, asynchronous, low = pressed
//   key_rot_n     in   raw rotate button, asynchronous, low = pressed
//   grav_pause    in   1 = freeze the gravity counter
//   left_final    out  1-cycle left request
//   right_final   out  1-cycle right request
//   rot_final     out  1-cycle rotate request
//   tick_gravity  out  1-cycle gravity request
// -----------------------------------------------------------------------------
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int GRAV_PERIOD     = 25_000_000,
  parameter int DAS_DELAY       = 10_000_000,
  parameter int DAS_RATE        = 2_500_000
) (
  input  logic CLOCK_50,
  input  logic resetn,
  input  logic key_left_n,
  input  logic key_right_n,
  input  logic key_rot_n,
  input  logic grav_pause,
  output logic left_final,
  output logic right_final,
  output logic rot_final,
  output logic tick_gravity
);

`ifdef AUTOREPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  // Repeat counters still exist in the source but their events are forced
  // low, so they have no load and are removed by synthesis.
  localparam bit REPEAT_ON = 1'b0;
`endif

  localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int GR_W    = (GRAV_PERIOD > 1) ? $clog2(GRAV_PERIOD) : 1;
  localparam int DAS_MAX = (DAS_DELAY > DAS_RATE) ? DAS_DELAY : DAS_RATE;
  localparam int RP_W    = (DAS_MAX > 1) ? $clog2(DAS_MAX) : 1;

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [GR_W-1:0] GR_LAST   = GR_W'(GRAV_PERIOD - 1);
  localparam logic [RP_W-1:0] DLY_LAST  = RP_W'(DAS_DELAY - 1);
  localparam logic [RP_W-1:0] RATE_LAST = RP_W'(DAS_RATE - 1);

  // Key vectors are indexed [0]=left, [1]=right, [2]=rot.
  // Request vectors add [3]=gravity; lower index = higher priority.

  // ---------------------------------------------------------------------------
  // Synchronizers (inverted so 1 = pressed)
  // ---------------------------------------------------------------------------
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ~{key_rot_n, key_right_n, key_left_n};
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce: stable value changes only after DEBOUNCE_CYCLES consecutive
  // disagreeing samples; any agreement restarts the count.
  // ---------------------------------------------------------------------------
  logic [2:0]      stable_q;
  logic [2:0]      stable_d;
  logic [2:0]      stable_prev_q;
  logic [DB_W-1:0] db_cnt_q [3];
  logic [DB_W-1:0] db_cnt_d [3];

  always_comb begin
    stable_d = stable_q;
    for (int unsigned k = 0; k < 3; k++) begin
      db_cnt_d[k] = '0;
      if (sync2_q[k] != stable_q[k]) begin
        if (db_cnt_q[k] == DB_LAST) begin
          stable_d[k] = sync2_q[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      stable_q      <= '0;
      stable_prev_q <= '0;
      db_cnt_q      <= '{default: '0};
    end else begin
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      db_cnt_q      <= db_cnt_d;
    end
  end

  // Release produces no event; only the 0->1 edge of stable does.
  logic [2:0] press;
  assign press = stable_q & ~stable_prev_q;

  // ---------------------------------------------------------------------------
  // Auto-repeat for left/right. The counter restarts on the press event and
  // on any cycle the key is released; rep_rate_q selects the initial delay
  // (0) or the repeat interval (1).
  // ---------------------------------------------------------------------------
  logic [1:0]      rep_rate_q;
  logic [1:0]      rep_rate_d;
  logic [1:0]      rep_fire;
  logic [RP_W-1:0] rep_cnt_q [2];
  logic [RP_W-1:0] rep_cnt_d [2];

  always_comb begin
    rep_rate_d = rep_rate_q;
    rep_fire   = '0;
    rep_cnt_d  = rep_cnt_q;
    for (int unsigned k = 0; k < 2; k++) begin
      if (press[k] || !stable_q[k]) begin
        rep_cnt_d[k]  = '0;
        rep_rate_d[k] = 1'b0;
      end else if (rep_cnt_q[k] == (rep_rate_q[k] ? RATE_LAST : DLY_LAST)) begin
        rep_fire[k]   = REPEAT_ON;
        rep_cnt_d[k]  = '0;
        rep_rate_d[k] = 1'b1;
      end else begin
        rep_cnt_d[k] = rep_cnt_q[k] + RP_W'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      rep_rate_q <= '0;
      rep_cnt_q  <= '{default: '0};
    end else begin
      rep_rate_q <= rep_rate_d;
      rep_cnt_q  <= rep_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Gravity counter: free-running 0..GRAV_PERIOD-1 unless paused. The event
  // is raised on the wrap, so arbiter delays never shift the counter phase.
  // ---------------------------------------------------------------------------
  logic [GR_W-1:0] grav_cnt_q;
  logic [GR_W-1:0] grav_cnt_d;
  logic            grav_evt;

  always_comb begin
    grav_cnt_d = grav_cnt_q;
    grav_evt   = 1'b0;
    if (!grav_pause) begin
      if (grav_cnt_q == GR_LAST) begin
        grav_cnt_d = '0;
        grav_evt   = 1'b1;
      end else begin
        grav_cnt_d = grav_cnt_q + GR_W'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      grav_cnt_q <= '0;
    end else begin
      grav_cnt_q <= grav_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending flags and fixed-priority arbiter
  // ---------------------------------------------------------------------------
  logic [3:0] evt;
  logic [3:0] pend_q;
  logic [3:0] pend_d;
  logic [3:0] grant;
  logic [3:0] out_q;

  assign evt = {grav_evt, press | {1'b0, rep_fire}};

  always_comb begin
    grant = '0;
    if (pend_q[0]) begin
      grant[0] = 1'b1;
    end else if (pend_q[1]) begin
      grant[1] = 1'b1;
    end else if (pend_q[2]) begin
      grant[2] = 1'b1;
    end else if (pend_q[3]) begin
      grant[3] = 1'b1;
    end
  end

  // A new event on a flag being issued this cycle re-sets it; an event on a
  // flag that stays pending merges into it.
  assign pend_d = (pend_q & ~grant) | evt;

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      pend_q <= '0;
      out_q  <= '0;
    end else begin
      pend_q <= pend_d;
      out_q  <= grant;
    end
  end

  assign left_final   = out_q[0];
  assign right_final  = out_q[1];
  assign rot_final    = out_q[2];
  assign tick_gravity = out_q[3];

endmodule

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
//
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4, GRAV_PERIOD=10,
// DAS_DELAY=8, DAS_RATE=3. A behavioural model derives the expected request
// outputs from the button/pause/reset history every cycle; pulse-cycle lists
// for each scenario are also checked against hand-derived values. Cycle n of
// a scenario is the cycle following the n-th clock edge after the stimulus
// first becomes visible (edge 0 = first edge sampling it).
// -----------------------------------------------------------------------------
module tb_input_conditioner;

  localparam int DB = 4;
  localparam int GP = 10;
  localparam int DD = 8;
  localparam int DR = 3;

`ifdef AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  logic kl     = 1'b1;
  logic kr     = 1'b1;
  logic ko     = 1'b1;
  logic pause  = 1'b1;
  logic lf, rf, of, tg;

  input_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .GRAV_PERIOD    (GP),
    .DAS_DELAY      (DD),
    .DAS_RATE       (DR)
  ) dut (
    .CLOCK_50    (clk),
    .resetn      (resetn),
    .key_left_n  (kl),
    .key_right_n (kr),
    .key_rot_n   (ko),
    .grav_pause  (pause),
    .left_final  (lf),
    .right_final (rf),
    .rot_final   (of),
    .tick_gravity(tg)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int en     = -1;        // index of most recent rising edge
  int pl[4][$];           // edges after which each output was seen high

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  bit       dl [3][2];    // raw pressed samples, two edges of latency
  bit       hist [3][$];  // last DB samples seen by the debouncer
  bit [2:0] m_stable;
  bit [2:0] m_prev;
  int       pedge [3];    // edge of the last press event, -1 if released
  int       act;          // unpaused edges since reset
  bit [3:0] m_pend;
  bit [3:0] mout;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      dl[k][0] = 1'b0;
      dl[k][1] = 1'b0;
      hist[k].delete();
      pedge[k] = -1;
    end
    m_stable = '0;
    m_prev   = '0;
    act      = 0;
    m_pend   = '0;
    mout     = '0;
  endtask

  task automatic model_step();
    bit [3:0] ev;
    bit [3:0] gr;
    bit [2:0] now;
    bit       seen;
    bit       flip;
    int       t;
    now = {~ko, ~kr, ~kl};
    ev  = '0;
    for (int k = 0; k < 3; k++) begin
      seen     = dl[k][0];
      dl[k][0] = dl[k][1];
      dl[k][1] = now[k];
      if (m_stable[k] && !m_prev[k]) begin
        ev[k]    = 1'b1;
        pedge[k] = en;
      end else if (AR && k < 2 && m_stable[k] && pedge[k] >= 0) begin
        t = en - pedge[k];
        if (t == DD || (t > DD && (t - DD) % DR == 0)) ev[k] = 1'b1;
      end
      if (!m_stable[k]) pedge[k] = -1;
      hist[k].push_back(seen);
      if (hist[k].size() > DB) void'(hist[k].pop_front());
      flip = (hist[k].size() == DB);
      for (int i = 0; i < hist[k].size(); i++)
        if (hist[k][i] == m_stable[k]) flip = 1'b0;
      m_prev[k] = m_stable[k];
      if (flip) m_stable[k] = seen;
    end
    if (!pause) begin
      if (act % GP == GP - 1) ev[3] = 1'b1;
      act++;
    end
    gr = '0;
    for (int i = 0; i < 4; i++)
      if (m_pend[i] && gr == '0) gr[i] = 1'b1;
    m_pend = (m_pend & ~gr) | ev;
    mout   = gr;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      en++;
      if (!resetn) model_reset();
      else model_step();
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle comparison against the model, plus pulse logging
  // ---------------------------------------------------------------------------
  initial begin
    logic [3:0] act_o;
    forever begin
      @(negedge clk);
      act_o = {tg, of, rf, lf};
      checks++;
      if (act_o !== mout) begin
        errors++;
        $display("FAIL model_cmp edge %0d: outputs {grav,rot,right,left}=%b required %b",
                 en, act_o, mout);
      end
      checks++;
      if ($countones(act_o) > 1) begin
        errors++;
        $display("FAIL one_hot edge %0d: outputs=%b required at most one high", en, act_o);
      end
      for (int i = 0; i < 4; i++)
        if (act_o[i] === 1'b1) pl[i].push_back(en);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cyc(3);
    resetn = 1'b1;
  endtask

  task automatic check_win(input string name, input int src, input int base,
                           input int span, input int ex[$]);
    int    got[$];
    string gs;
    string es;
    bit    bad;
    for (int i = 0; i < pl[src].size(); i++)
      if (pl[src][i] >= base && pl[src][i] <= base + span)
        got.push_back(pl[src][i] - base);
    bad = (got.size() != ex.size());
    if (!bad)
      for (int i = 0; i < got.size(); i++)
        if (got[i] != ex[i]) bad = 1'b1;
    gs = "";
    es = "";
    for (int i = 0; i < got.size(); i++) gs = {gs, $sformatf(" %0d", got[i])};
    for (int i = 0; i < ex.size(); i++)  es = {es, $sformatf(" %0d", ex[i])};
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s: pulse cycles {%s } required {%s }", name, gs, es);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  initial begin
    int b;
    int b2;
    int e[$];

    cyc(2);
    checks++;
    if ({tg, of, rf, lf} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: outputs=%b required 0000", {tg, of, rf, lf});
    end
    resetn = 1'b1;
    cyc(3);

    // 1: clean press, then a second press
    kl = 1'b0; b = en + 1; cyc(8); kl = 1'b1; cyc(20);
    e.delete(); e.push_back(7);
    check_win("t1_left", 0, b, 25, e);
    e.delete();
    check_win("t1_right", 1, b, 25, e);
    kl = 1'b0; b = en + 1; cyc(8); kl = 1'b1; cyc(20);
    e.delete(); e.push_back(7);
    check_win("t1_left_again", 0, b, 25, e);

    // 2: bouncing rotate never accepted
    b = en + 1;
    for (int i = 0; i < 10; i++) begin
      ko = 1'b0; cyc(2);
      ko = 1'b1; cyc(2);
    end
    cyc(20);
    e.delete();
    check_win("t2_rot", 2, b, 58, e);

    // 3: simultaneous left/right
    kl = 1'b0; kr = 1'b0; b = en + 1; cyc(8); kl = 1'b1; kr = 1'b1; cyc(20);
    e.delete(); e.push_back(7);
    check_win("t3_left", 0, b, 25, e);
    e.delete(); e.push_back(8);
    check_win("t3_right", 1, b, 25, e);

    // 4: gravity cadence with a 5-cycle pause from cycle 32
    pause = 1'b0;
    do_reset();
    b = en + 1;
    cyc(33); pause = 1'b1;
    cyc(5);  pause = 1'b0;
    cyc(15); pause = 1'b1;
    e.delete(); e.push_back(10); e.push_back(20); e.push_back(30); e.push_back(45);
    check_win("t4_grav", 3, b, 50, e);
    cyc(5);

    // 5: long hold of left
    do_reset();
    cyc(2);
    kl = 1'b0; b = en + 1; cyc(26); kl = 1'b1; cyc(30);
    e.delete(); e.push_back(7);
    if (AR) begin
      e.push_back(15); e.push_back(18); e.push_back(21);
      e.push_back(24); e.push_back(27); e.push_back(30);
    end
    check_win("t5_left", 0, b, 55, e);
    cyc(5);

    // 6: reset in the cycle left's pend is set, key still held
    kl = 1'b0; b = en + 1; cyc(7);
    do_reset();
    b2 = en + 1;
    cyc(7); kl = 1'b1; cyc(25);
    e.delete();
    check_win("t6_left_dropped", 0, b, b2 - b - 1, e);
    e.delete(); e.push_back(7);
    check_win("t6_left_after", 0, b2, 30, e);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
